// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rr_arbiter
// Description : Round-robin read scheduler that drains four upstream FIFOs
//               into one downstream FIFO. It issues at most one read strobe
//               per cycle and forwards each word two cycles later, stopping
//               new grants while the downstream FIFO reports almost-full.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter #(
    parameter int DATA_W = 10,
    parameter int N_CH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          chan_en,
    input  logic [N_CH-1:0]          fifo_empty,
    input  logic [N_CH*DATA_W-1:0]   fifo_data,
    input  logic                     out_almost_full,
    output logic [N_CH-1:0]          rd_enb,
    output logic                     wr_enb,
    output logic [DATA_W-1:0]        data_out,
    output logic [1:0]               grant_idx,
    output logic                     idle
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_grant_idx;
    logic              r_vld1;
    logic [1:0]        r_ch1;
    logic              r_wr;
    logic [DATA_W-1:0] r_dout;

    logic [3:0]        w_elig;
    logic [7:0]        w_elig2;
    logic [1:0]        w_start;
    logic [3:0]        w_rot;
    logic [1:0]        w_off;
    logic              w_found;
    logic [1:0]        w_sel;
    logic              w_do_grant;
    logic [1:0]        w_state_nxt;

    assign w_elig  = chan_en & ~fifo_empty;
    // Duplicate the mask so a 4-bit window starting after the last grant
    // gives the search order without wrap-around logic.
    assign w_elig2 = {w_elig, w_elig};
    assign w_start = r_grant_idx + 2'd1;
    assign w_rot   = w_elig2[w_start +: 4];

    // Find the first eligible channel in rotation order.
    always_comb begin
        w_found = 1'b1;
        w_off   = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
        else               w_found = 1'b0;
    end

    assign w_sel      = w_start + w_off;
    // Grants stop in the same cycle almost-full rises and stay off for the
    // STALL cycle that follows, so in-flight words never exceed two.
    assign w_do_grant = w_found & (r_state != S_STALL) & ~out_almost_full & ~rst;
    assign rd_enb     = w_do_grant ? (4'b0001 << w_sel) : 4'b0000;

    // Next-state selection; every state reacts to the same current inputs.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE, S_ARB, S_STALL: begin
                if (out_almost_full)  w_state_nxt = S_STALL;
                else if (|w_elig)     w_state_nxt = S_ARB;
                else                  w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and rotation pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant_idx <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            if (w_do_grant) begin
                r_grant_idx <= w_sel;
            end
        end
    end

    // Read pipeline: remember which channel was read, then capture its word
    // the following cycle and present it as the downstream write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld1 <= 1'b0;
            r_ch1  <= 2'd0;
            r_wr   <= 1'b0;
            r_dout <= '0;
        end else begin
            r_vld1 <= w_do_grant;
            if (w_do_grant) begin
                r_ch1 <= w_sel;
            end
            r_wr <= r_vld1;
            if (r_vld1) begin
                r_dout <= fifo_data[r_ch1*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_enb    = r_wr;
    assign data_out  = r_dout;
    assign grant_idx = r_grant_idx;
    assign idle      = (r_state == S_IDLE) & ~r_vld1 & ~r_wr;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rr_arbiter
// Description : Scoreboard bench for fifo_rr_arbiter with upstream FIFO
//               models and a rotation-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_arbiter;
    localparam int DATA_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [3:0]            chan_en;
    logic [3:0]            fifo_empty;
    logic [4*DATA_W-1:0]   fifo_data;
    logic                  out_almost_full;
    logic [3:0]            rd_enb;
    logic                  wr_enb;
    logic [DATA_W-1:0]     data_out;
    logic [1:0]            grant_idx;
    logic                  idle;

    fifo_rr_arbiter #(.DATA_W(DATA_W), .N_CH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .chan_en         (chan_en),
        .fifo_empty      (fifo_empty),
        .fifo_data       (fifo_data),
        .out_almost_full (out_almost_full),
        .rd_enb          (rd_enb),
        .wr_enb          (wr_enb),
        .data_out        (data_out),
        .grant_idx       (grant_idx),
        .idle            (idle)
    );

    typedef struct {
        logic [DATA_W-1:0] word;
        int                due;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] src_q[4][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_on = 0;

    // Reference model state
    int                last_g    = 3;
    bit                prev_af   = 0;
    bit                prev_idle = 1;
    bit                cur_rst   = 1;
    bit                cur_af    = 0;
    bit                granted   = 0;
    int                gch       = 0;
    logic [DATA_W-1:0] pend      = '0;
    logic [3:0]        elig_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    // One clock cycle: apply edge effects to the model, drive new inputs,
    // then compare the combinational grant against the rotation rule.
    task automatic step(input bit r, input bit af, input logic [3:0] en, input int refill_pct);
        logic [3:0] el;
        logic [3:0] exp_rd;
        int         g;
        bit         was_rst;
        exp_t       e;
        @(posedge clk);
        #1;
        mon_on = 1;
        was_rst = cur_rst;
        if (cur_rst) begin
            last_g    = 3;
            prev_af   = 0;
            prev_idle = 1;
            exp_q.delete();
        end else begin
            if (granted) last_g = gch;
            prev_af   = cur_af;
            prev_idle = !cur_af && (elig_prev == 4'b0000);
        end
        if (granted) fifo_data[gch*DATA_W +: DATA_W] = pend;
        granted = 0;
        for (int ch = 0; ch < 4; ch++)
            if (int'($urandom_range(99)) < refill_pct && src_q[ch].size() < 8)
                src_q[ch].push_back(DATA_W'($urandom_range(1023)));
        rst = r; out_almost_full = af; chan_en = en;
        cur_rst = r; cur_af = af;
        for (int ch = 0; ch < 4; ch++) fifo_empty[ch] = (src_q[ch].size() == 0);
        #1;
        chk("grant_idx", 32'(grant_idx), 32'(last_g));
        chk("idle", 32'(idle), 32'(prev_idle && exp_q.size() == 0));
        if (was_rst) begin
            chk("wr_enb_after_rst", 32'(wr_enb), 32'd0);
            chk("data_out_after_rst", 32'(data_out), 32'd0);
        end
        el = chan_en & ~fifo_empty;
        exp_rd = 4'b0000;
        g = -1;
        if (!r && !af && !prev_af)
            for (int k = 1; k <= 4; k++)
                if (g < 0 && el[(last_g + k) % 4]) g = (last_g + k) % 4;
        if (g >= 0) exp_rd[g] = 1'b1;
        chk("rd_enb", 32'(rd_enb), 32'(exp_rd));
        elig_prev = el;
        if (g >= 0) begin
            granted = 1;
            gch     = g;
            pend    = src_q[g].pop_front();
            e.word  = pend;
            e.due   = cyc + 2;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every downstream write must match the oldest outstanding word
    // and arrive exactly two cycles after its grant.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_on) begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_write at cycle %0d: got none expected %0h", cyc, exp_q[0].word);
                void'(exp_q.pop_front());
            end
            if (wr_enb === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write at cycle %0d: got %0h expected no write", cyc, data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e.word || e.due != cyc) begin
                        errors++;
                        $display("FAIL write_data at cycle %0d: got %0h expected %0h due cycle %0d",
                                 cyc, data_out, e.word, e.due);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; chan_en = 4'h0; fifo_empty = 4'hF; fifo_data = '0; out_almost_full = 1'b0;
        // Reset held two cycles
        step(1, 0, 4'hF, 0);
        step(1, 0, 4'hF, 0);
        // Only FIFO0 holds three words
        src_q[0].push_back(10'd10); src_q[0].push_back(10'd15); src_q[0].push_back(10'd20);
        repeat (8) step(0, 0, 4'hF, 0);
        // All FIFOs loaded with 100*i+k
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) src_q[i].push_back(10'(100 * i + k));
        repeat (8) step(0, 0, 4'hF, 0);
        // Steady stream with a 3-cycle almost-full burst
        repeat (6) step(0, 0, 4'hF, 100);
        repeat (3) step(0, 1, 4'hF, 100);
        repeat (6) step(0, 0, 4'hF, 100);
        // Only channels 1 and 3 enabled
        repeat (10) step(0, 0, 4'b1010, 100);
        // Reset in the middle of a stream
        repeat (4) step(0, 0, 4'hF, 100);
        step(1, 0, 4'hF, 100);
        repeat (6) step(0, 0, 4'hF, 100);
        // Randomised traffic
        for (int n = 0; n < 1500; n++)
            step($urandom_range(99) < 2, $urandom_range(99) < 15,
                 ($urandom_range(99) < 60) ? 4'hF : 4'($urandom_range(15)),
                 int'($urandom_range(80)));
        // Drain everything
        repeat (60) step(0, 0, 4'hF, 0);
        @(negedge clk);
        @(negedge clk);
        chk("drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
